common_pseudo_lru_way_allocator: RTL and testbench

Allocation-side controller for a pseudo-LRU replacement tree with one-hot touch/query ports. It accepts way-allocation requests from a cache refill path and picks a way. The lowest-index invalid way is chosen if one exists; otherwise the tree's current victim is used. The choice is held until the requester commits or aborts. It drives touch updates into the tree for committed allocations and for hits, and owns the per-way valid bits.

---
 rtl/common_pseudo_lru_pkg.sv | 8 +
 rtl/common_onehot_lowest_select.sv | 10 +
 rtl/common_pseudo_lru_way_allocator.sv | 77 +++++++
 tb/tb_common_pseudo_lru_way_allocator.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/common_pseudo_lru_pkg.sv
// common_pseudo_lru_pkg: shared FSM state and way-count helpers for the pseudo-LRU allocator.
package common_pseudo_lru_pkg;
    typedef enum logic [1:0] {IDLE, SELECT, RESP} alloc_state_e;
    localparam int unsigned WAY_COUNT_LOG2_DEFAULT = 2;
    function automatic int unsigned way_count(input int unsigned log2);
        return 32'd1 << log2;
    endfunction
endpackage

// File: rtl/common_onehot_lowest_select.sv
// common_onehot_lowest_select: one-hot mask of the lowest set bit of the input.
module common_onehot_lowest_select #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] in_i,
    output logic [W-1:0] out_o
);
    // Two's complement isolates the lowest set bit; all-zero input yields zero.
    assign out_o = in_i & (-in_i);
endmodule

// File: rtl/common_pseudo_lru_way_allocator.sv
// common_pseudo_lru_way_allocator: picks a refill way (first invalid, else tree victim),
// holds it until commit/abort, and arbitrates touch updates into the external PLRU tree.
module common_pseudo_lru_way_allocator
    import common_pseudo_lru_pkg::*;
#(
    parameter  int unsigned WAY_COUNT_LOG2 = WAY_COUNT_LOG2_DEFAULT,
    localparam int unsigned W = way_count(WAY_COUNT_LOG2)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         alloc_req_valid,
    output logic         alloc_req_ready,
    output logic         alloc_resp_valid,
    output logic [W-1:0] alloc_resp_way,
    output logic         alloc_resp_replace,
    input  logic         alloc_commit,
    input  logic         alloc_abort,
    input  logic         hit_valid,
    input  logic [W-1:0] hit_way,
    input  logic         inv_valid,
    input  logic [W-1:0] inv_way,
    output logic [W-1:0] plru_waddr,
    output logic         plru_wen,
    input  logic [W-1:0] plru_qaddr,
    output logic [W-1:0] way_valid
);
    alloc_state_e state_q;
    logic [W-1:0] resp_way_q, way_valid_q, skid_way_q, plru_waddr_q, lowest_free;
    logic         replace_q, skid_valid_q, plru_wen_q, commit;

    common_onehot_lowest_select #(.W(W)) u_lowest (
        .in_i  (~way_valid_q),
        .out_o (lowest_free)
    );

    assign commit = (state_q == RESP) && alloc_commit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            resp_way_q   <= '0;
            replace_q    <= 1'b0;
            way_valid_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_way_q   <= '0;
            plru_wen_q   <= 1'b0;
            plru_waddr_q <= '0;
        end else begin
            case (state_q)
                IDLE:    if (alloc_req_valid) state_q <= SELECT;
                SELECT: begin
                    resp_way_q <= &way_valid_q ? plru_qaddr : lowest_free;
                    replace_q  <= &way_valid_q;
                    state_q    <= RESP;
                end
                RESP:    if (alloc_commit || alloc_abort) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // Commit is OR-ed in after the invalidate mask so it wins on the same way.
            way_valid_q  <= (way_valid_q & ~(inv_valid ? inv_way : '0)) | (commit ? resp_way_q : '0);
            plru_wen_q   <= commit || skid_valid_q || hit_valid;
            plru_waddr_q <= commit ? resp_way_q : skid_valid_q ? skid_way_q : hit_valid ? hit_way : '0;
            skid_valid_q <= commit && hit_valid;
            if (commit && hit_valid) skid_way_q <= hit_way;
        end
    end

    assert property (@(posedge clk) disable iff (!reset) !(commit && skid_valid_q));

    assign alloc_req_ready    = (state_q == IDLE);
    assign alloc_resp_valid   = (state_q == RESP);
    assign alloc_resp_way     = resp_way_q;
    assign alloc_resp_replace = replace_q;
    assign plru_wen           = plru_wen_q;
    assign plru_waddr         = plru_waddr_q;
    assign way_valid          = way_valid_q;
endmodule

// File: tb/tb_common_pseudo_lru_way_allocator.sv
// tb_common_pseudo_lru_way_allocator: directed vectors with hand-computed expectations.
module tb_common_pseudo_lru_way_allocator;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_req_valid, alloc_req_ready, alloc_resp_valid, alloc_resp_replace;
    logic [3:0] alloc_resp_way;
    logic       alloc_commit, alloc_abort, hit_valid, inv_valid, plru_wen;
    logic [3:0] hit_way, inv_way, plru_waddr, plru_qaddr, way_valid;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    common_pseudo_lru_way_allocator #(.WAY_COUNT_LOG2(2)) dut (
        .clk                (clk),
        .reset              (rst_n),
        .alloc_req_valid    (alloc_req_valid),
        .alloc_req_ready    (alloc_req_ready),
        .alloc_resp_valid   (alloc_resp_valid),
        .alloc_resp_way     (alloc_resp_way),
        .alloc_resp_replace (alloc_resp_replace),
        .alloc_commit       (alloc_commit),
        .alloc_abort        (alloc_abort),
        .hit_valid          (hit_valid),
        .hit_way            (hit_way),
        .inv_valid          (inv_valid),
        .inv_way            (inv_way),
        .plru_waddr         (plru_waddr),
        .plru_wen           (plru_wen),
        .plru_qaddr         (plru_qaddr),
        .way_valid          (way_valid)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Runs one allocation from IDLE; all calls start and end on a falling edge.
    task automatic alloc(input logic [3:0] exp_way, input logic exp_rep, input logic cmt,
                         input logic abt, input logic inv_en, input logic [3:0] inv_w);
        check("ready", {15'd0, alloc_req_ready}, 16'd1);
        alloc_req_valid = 1'b1;
        @(negedge clk);
        alloc_req_valid = 1'b0;
        check("select_resp_valid", {15'd0, alloc_resp_valid}, 16'd0);
        @(negedge clk);
        check("resp_valid", {15'd0, alloc_resp_valid}, 16'd1);
        check("resp_way", {12'd0, alloc_resp_way}, {12'd0, exp_way});
        check("resp_replace", {15'd0, alloc_resp_replace}, {15'd0, exp_rep});
        alloc_commit = cmt;
        alloc_abort  = abt;
        inv_valid    = inv_en;
        inv_way      = inv_w;
        @(negedge clk);
        alloc_commit = 1'b0;
        alloc_abort  = 1'b0;
        inv_valid    = 1'b0;
        check("touch_wen", {15'd0, plru_wen}, {15'd0, cmt});
        check("touch_addr", {12'd0, plru_waddr}, cmt ? {12'd0, exp_way} : 16'd0);
        check("ready_after", {15'd0, alloc_req_ready}, 16'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_req_valid = 1'b0; alloc_commit = 1'b0; alloc_abort = 1'b0;
        hit_valid = 1'b0; hit_way = '0; inv_valid = 1'b0; inv_way = '0; plru_qaddr = 4'b0001;
        @(negedge clk);
        check("rst_ready", {15'd0, alloc_req_ready}, 16'd1);
        check("rst_resp_valid", {15'd0, alloc_resp_valid}, 16'd0);
        check("rst_wen", {15'd0, plru_wen}, 16'd0);
        check("rst_valid", {12'd0, way_valid}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill from empty.
        alloc(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        alloc(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        alloc(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        alloc(4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        check("fill_valid", {12'd0, way_valid}, 16'b1111);

        // Victim path, abort, commit+abort.
        plru_qaddr = 4'b0100;
        alloc(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        plru_qaddr = 4'b0010;
        alloc(4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        check("abort_valid", {12'd0, way_valid}, 16'b1111);
        alloc(4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);

        // Touch collision: commit 1000 with hit 0001, then a dropped hit 0100.
        plru_qaddr = 4'b1000;
        alloc_req_valid = 1'b1;
        @(negedge clk);
        alloc_req_valid = 1'b0;
        @(negedge clk);
        check("coll_resp_way", {12'd0, alloc_resp_way}, 16'b1000);
        alloc_commit = 1'b1; hit_valid = 1'b1; hit_way = 4'b0001;
        @(negedge clk);
        alloc_commit = 1'b0; hit_way = 4'b0100;
        check("coll_n1_wen", {15'd0, plru_wen}, 16'd1);
        check("coll_n1_addr", {12'd0, plru_waddr}, 16'b1000);
        @(negedge clk);
        hit_valid = 1'b0;
        check("coll_n2_wen", {15'd0, plru_wen}, 16'd1);
        check("coll_n2_addr", {12'd0, plru_waddr}, 16'b0001);
        @(negedge clk);
        check("coll_drop_wen", {15'd0, plru_wen}, 16'd0);

        // Invalidate, then reallocate the freed way.
        inv_valid = 1'b1; inv_way = 4'b0010;
        @(negedge clk);
        inv_valid = 1'b0;
        check("inv_valid", {12'd0, way_valid}, 16'b1101);
        check("inv_no_touch", {15'd0, plru_wen}, 16'd0);
        alloc(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        check("realloc_valid", {12'd0, way_valid}, 16'b1111);

        // Invalidate and commit on the same way together.
        inv_valid = 1'b1; inv_way = 4'b0100;
        @(negedge clk);
        inv_valid = 1'b0;
        check("inv2_valid", {12'd0, way_valid}, 16'b1011);
        alloc(4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100);
        check("inv_commit_valid", {12'd0, way_valid}, 16'b1111);

        // Asynchronous reset while in RESP.
        alloc_req_valid = 1'b1;
        @(negedge clk);
        alloc_req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_resp", {15'd0, alloc_resp_valid}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", {15'd0, alloc_req_ready}, 16'd1);
        check("arst_resp_valid", {15'd0, alloc_resp_valid}, 16'd0);
        check("arst_resp_way", {12'd0, alloc_resp_way}, 16'd0);
        check("arst_replace", {15'd0, alloc_resp_replace}, 16'd0);
        check("arst_waddr", {12'd0, plru_waddr}, 16'd0);
        check("arst_valid", {12'd0, way_valid}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        alloc(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        check("post_rst_valid", {12'd0, way_valid}, 16'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
